// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame packer: framing FSM states
// and frame layout constants.
package adc_frame_pkg;

   localparam int         FRAME_BYTES       = 4;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Byte states are numbered by their position in the frame (1..FRAME_BYTES).
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CHK  = 3'(FRAME_BYTES)
   } state_t;

endpackage

// File: rtl/adc_frame_packer_decimator.sv
// Sample decimator: flags every DECIM-th valid input sample. The counter runs
// on every valid pulse regardless of what the downstream framer is doing.
module sample_decimator #(
   parameter int DECIM = 2000
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   output logic select_o
);

   localparam int                 CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DECIM - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last   = (r_cnt == LAST);
   assign select_o = valid_i & w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (valid_i) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs decimated 12-bit ADC samples into 4-byte frames (SYNC, HI, LO, CHK)
// for a UART transmit FIFO; samples selected while a frame is in flight are dropped.
module adc_frame_packer
   import adc_frame_pkg::*;
#(
   parameter int         DECIM     = 2000,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample_i,
   input  logic        valid_i,
   input  logic        fifo_full_i,
   output logic [7:0]  data_o,
   output logic        wr_en_o,
   output logic        drop_o,
   output logic [7:0]  drop_count_o,
   output logic        busy_o
);

   state_t      r_state;
   state_t      w_next;
   logic [11:0] r_sample;
   logic [3:0]  r_seq;
   logic [7:0]  r_drop_cnt;
   logic        w_select;
   logic        w_capture;
   logic        w_drop;
   logic        w_write;
   logic [7:0]  w_hi;
   logic [7:0]  w_lo;
   logic [7:0]  w_data;

   sample_decimator #(.DECIM(DECIM)) u_decim (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .select_o (w_select)
   );

   assign w_write   = (r_state != ST_IDLE) & ~fifo_full_i;
   assign w_capture = w_select & (r_state == ST_IDLE);
   assign w_drop    = w_select & (r_state != ST_IDLE);
   assign w_hi      = {r_seq, r_sample[11:8]};
   assign w_lo      = r_sample[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Every byte state holds until the FIFO accepts its byte.
   always_comb begin
      w_next = r_state;
      w_data = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) w_next = ST_SYNC;
         end
         ST_SYNC: begin
            w_data = SYNC_BYTE;
            if (!fifo_full_i) w_next = ST_HI;
         end
         ST_HI: begin
            w_data = w_hi;
            if (!fifo_full_i) w_next = ST_LO;
         end
         ST_LO: begin
            w_data = w_lo;
            if (!fifo_full_i) w_next = ST_CHK;
         end
         ST_CHK: begin
            w_data = w_hi ^ w_lo;
            if (!fifo_full_i) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample   <= '0;
         r_seq      <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_capture) r_sample <= sample_i;
         if (r_state == ST_CHK && !fifo_full_i) r_seq <= r_seq + 4'd1;
         if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign data_o       = w_data;
   assign wr_en_o      = w_write;
   assign drop_o       = w_drop;
   assign drop_count_o = r_drop_cnt;
   assign busy_o       = (r_state != ST_IDLE);

endmodule
